uart_rx_param: RTL and testbench

Parametrised UART receiver with an oversampled bit clock, configurable frame format (data width, optional parity, 1 or 2 stop bits), an input synchroniser, false-start rejection, and parity/framing/break error reporting. It sits between the board's serial input pin and the debug/pipeline control logic. It takes the shared baud-rate tick from the existing baud generator and delivers one parallel word per frame, together with a single-cycle done strobe and status flags.

---
 rtl/uart_rx_param.sv | 138 +++++++++++++
 tb/tb_uart_rx_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampled UART receiver with parity, framing and break detection
module uart_rx_param #(
   parameter int D_BIT      = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s_tick,
   input  logic             rx,
   output logic             rx_done,
   output logic [D_BIT-1:0] d_out,
   output logic             parity_err,
   output logic             frame_err,
   output logic             rx_busy
);
   localparam int SW = $clog2(SB_TICK);
   localparam int NW = $clog2(D_BIT + 1);
   localparam logic [SW-1:0] S_MID  = SW'(SB_TICK / 2 - 1);
   localparam logic [SW-1:0] S_END  = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_DATA = NW'(D_BIT - 1);
   localparam logic [NW-1:0] N_STOP = NW'(STOP_BITS - 1);
   localparam logic          ODD    = (PARITY_ODD != 0);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] PARITY    = 3'd3;
   localparam logic [2:0] STOP      = 3'd4;
   localparam logic [2:0] WAIT_HIGH = 3'd5;

   logic             rx_m, rx_s;
   logic [2:0]       state;
   logic [SW-1:0]    s;
   logic [NW-1:0]    n;
   logic [D_BIT-1:0] b;
   logic             p_err, f_err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         s          <= '0;
         n          <= '0;
         b          <= '0;
         p_err      <= 1'b0;
         f_err      <= 1'b0;
         rx_done    <= 1'b0;
         d_out      <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         if (s_tick) begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state <= START;
                     s     <= '0;
                  end
               end
               // Half a bit in, re-check the line so a short glitch is not taken as a frame.
               START: begin
                  if (s == S_MID) begin
                     s     <= '0;
                     n     <= '0;
                     p_err <= 1'b0;
                     f_err <= 1'b0;
                     state <= rx_s ? IDLE : DATA;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
               DATA: begin
                  if (s == S_END) begin
                     s <= '0;
                     b <= {rx_s, b[D_BIT-1:1]};
                     if (n == N_DATA) begin
                        n     <= '0;
                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
               PARITY: begin
                  if (s == S_END) begin
                     s     <= '0;
                     p_err <= ((^b) ^ rx_s) != ODD;
                     state <= STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
               STOP: begin
                  if (s == S_END) begin
                     s <= '0;
                     if (n == N_STOP) begin
                        n          <= '0;
                        rx_done    <= 1'b1;
                        d_out      <= b;
                        parity_err <= p_err;
                        frame_err  <= f_err | ~rx_s;
                        state      <= (f_err | ~rx_s) ? WAIT_HIGH : IDLE;
                     end else begin
                        n     <= n + 1'b1;
                        f_err <= f_err | ~rx_s;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
               // A held-low line (break) must go high before another start is accepted.
               WAIT_HIGH: begin
                  if (rx_s) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param over three frame formats
module tb_uart_rx_param;

   typedef struct {
      logic [8:0] d;
      logic       perr;
      logic       ferr;
   } exp_t;

   // lane 0: 8N1/16, lane 1: 8E2/16, lane 2: 7O1/8
   int cfg_dbit [3] = '{8, 8, 7};
   int cfg_sb   [3] = '{16, 16, 8};
   int cfg_pen  [3] = '{0, 1, 1};
   int cfg_odd  [3] = '{0, 0, 1};
   int cfg_stop [3] = '{1, 2, 1};

   logic clock, reset, s_tick;
   logic rx_l [3];
   logic done_l [3], busy_l [3], perr_l [3], ferr_l [3];
   logic [8:0] dout_l [3];
   logic [7:0] d0, d1;
   logic [6:0] d2;
   int tick_per;
   int total = 0;
   int bad = 0;
   exp_t q [3][$];

   uart_rx_param dut0 (.clock(clock), .reset(reset), .s_tick(s_tick), .rx(rx_l[0]),
      .rx_done(done_l[0]), .d_out(d0), .parity_err(perr_l[0]), .frame_err(ferr_l[0]), .rx_busy(busy_l[0]));
   uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (.clock(clock), .reset(reset),
      .s_tick(s_tick), .rx(rx_l[1]), .rx_done(done_l[1]), .d_out(d1), .parity_err(perr_l[1]),
      .frame_err(ferr_l[1]), .rx_busy(busy_l[1]));
   uart_rx_param #(.D_BIT(7), .SB_TICK(8), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (.clock(clock),
      .reset(reset), .s_tick(s_tick), .rx(rx_l[2]), .rx_done(done_l[2]), .d_out(d2),
      .parity_err(perr_l[2]), .frame_err(ferr_l[2]), .rx_busy(busy_l[2]));

   assign dout_l[0] = {1'b0, d0};
   assign dout_l[1] = {1'b0, d1};
   assign dout_l[2] = {2'b00, d2};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      int tcnt;
      tcnt   = 0;
      s_tick = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         tcnt   = (tcnt + 1 >= tick_per) ? 0 : tcnt + 1;
         s_tick = (tcnt == 0);
      end
   end

   task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s lane%0d: got %0h want %0h at %0t", nm, l, act, exp, $time);
      end
   endtask

   // Reference: the word is the data sent; parity is wrong when the total count of ones
   // (data + parity bit) has the wrong evenness; framing is wrong when any checked stop is low.
   function automatic exp_t model(input int l, input logic [8:0] d, input logic pbit, input logic [1:0] slow);
      exp_t e;
      e.d    = d;
      e.perr = (cfg_pen[l] != 0) && ((($countones(d) + int'(pbit)) % 2) != cfg_odd[l]);
      e.ferr = slow[0] || (cfg_stop[l] == 2 && slow[1]);
      return e;
   endfunction

   task automatic wait_ticks(input int n);
      int k;
      k = 0;
      while (k < n) begin
         @(posedge clock);
         if (s_tick) k++;
      end
   endtask

   task automatic set_rx(input int l, input logic v);
      #2 rx_l[l] = v;
   endtask

   task automatic send(input int l, input logic [8:0] data, input logic flip, input logic [1:0] slow, input logic push);
      logic [8:0] d;
      logic pbit;
      int sb;
      sb   = cfg_sb[l];
      d    = data & ((9'h1 << cfg_dbit[l]) - 9'h1);
      pbit = (($countones(d) % 2) == 1) ^ (cfg_odd[l] != 0) ^ flip;
      if (push) q[l].push_back(model(l, d, pbit, slow));
      set_rx(l, 1'b0);
      wait_ticks(sb);
      for (int i = 0; i < cfg_dbit[l]; i++) begin
         set_rx(l, d[i]);
         wait_ticks(sb);
      end
      if (cfg_pen[l] != 0) begin
         set_rx(l, pbit);
         wait_ticks(sb);
      end
      for (int i = 0; i < cfg_stop[l]; i++) begin
         set_rx(l, ~slow[i]);
         wait_ticks(sb);
      end
      set_rx(l, 1'b1);
      wait_ticks(5 + $urandom_range(0, 3));
   endtask

   task automatic brk(input int l);
      int ft;
      ft = cfg_sb[l] * (1 + cfg_dbit[l] + cfg_pen[l] + cfg_stop[l]);
      q[l].push_back(model(l, 9'h0, 1'b0, 2'b11));
      set_rx(l, 1'b0);
      wait_ticks(3 * ft);
      set_rx(l, 1'b1);
      wait_ticks(6);
   endtask

   task automatic lane_directed(input int l);
      send(l, 9'h055, 1'b0, 2'b00, 1'b1);
      send(l, 9'h0A3, 1'b0, 2'b00, 1'b1);
      set_rx(l, 1'b0);
      wait_ticks(3);
      set_rx(l, 1'b1);
      wait_ticks(cfg_sb[l] / 2 + 2);
      #3 chk("glitch_busy", l, 32'(busy_l[l]), 32'd0);
      send(l, 9'h00F, 1'b0, 2'b00, 1'b1);
      send(l, 9'h007, 1'b1, 2'b00, 1'b1);
      send(l, 9'h007, 1'b0, 2'b00, 1'b1);
      send(l, 9'h081, 1'b0, (cfg_stop[l] == 2) ? 2'b10 : 2'b01, 1'b1);
      send(l, 9'h081, 1'b0, 2'b00, 1'b1);
      brk(l);
      send(l, 9'h05A, 1'b0, 2'b00, 1'b1);
   endtask

   task automatic lane_random(input int l, input int n);
      repeat (n) begin
         logic [1:0] sl;
         sl = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send(l, 9'($urandom), ($urandom_range(0, 2) == 0), sl, 1'b1);
      end
   endtask

   task automatic check_cleared();
      for (int l = 0; l < 3; l++) begin
         chk("rst_done", l, 32'(done_l[l]), 32'd0);
         chk("rst_dout", l, 32'(dout_l[l]), 32'd0);
         chk("rst_perr", l, 32'(perr_l[l]), 32'd0);
         chk("rst_ferr", l, 32'(ferr_l[l]), 32'd0);
         chk("rst_busy", l, 32'(busy_l[l]), 32'd0);
      end
   endtask

   // Monitor: pops one expectation per rx_done and checks outputs hold between strobes.
   logic       prev_done [3];
   logic [10:0] prev_out [3];
   always @(negedge clock) begin
      for (int l = 0; l < 3; l++) begin
         if (!reset) begin
            if (done_l[l]) begin
               chk("done_width", l, 32'(prev_done[l]), 32'd0);
               if (q[l].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done lane%0d: got d_out %0h want no strobe at %0t", l, dout_l[l], $time);
               end else begin
                  exp_t e;
                  e = q[l].pop_front();
                  chk("d_out", l, 32'(dout_l[l]), 32'(e.d));
                  chk("parity_err", l, 32'(perr_l[l]), 32'(e.perr));
                  chk("frame_err", l, 32'(ferr_l[l]), 32'(e.ferr));
               end
            end else begin
               chk("hold", l, 32'({dout_l[l], perr_l[l], ferr_l[l]}), 32'(prev_out[l]));
            end
         end
         prev_done[l] = done_l[l];
         prev_out[l]  = {dout_l[l], perr_l[l], ferr_l[l]};
      end
   end

   initial begin
      int guard;
      reset    = 1'b1;
      tick_per = 4;
      for (int l = 0; l < 3; l++) rx_l[l] = 1'b1;
      repeat (5) @(posedge clock);
      #2 check_cleared();
      reset = 1'b0;
      wait_ticks(4);

      fork
         lane_directed(0);
         lane_directed(1);
         lane_directed(2);
      join
      fork
         lane_random(0, 8);
         lane_random(1, 8);
         lane_random(2, 8);
      join
      tick_per = 1;
      wait_ticks(4);
      fork
         lane_random(0, 4);
         lane_random(1, 4);
         lane_random(2, 4);
      join
      tick_per = 4;
      wait_ticks(4);
      fork
         send(0, 9'h03C, 1'b0, 2'b00, 1'b1);
         send(1, 9'h03C, 1'b0, 2'b00, 1'b1);
         send(2, 9'h03C, 1'b0, 2'b00, 1'b1);
      join

      // Reset lands in data bit 4 of each lane's frame; the partial frames must vanish.
      fork
         send(0, 9'h0C6, 1'b0, 2'b00, 1'b0);
         send(1, 9'h0C6, 1'b0, 2'b00, 1'b0);
         begin
            wait_ticks(44);
            send(2, 9'h0C6, 1'b0, 2'b00, 1'b0);
         end
         begin
            wait_ticks(84);
            #3 reset = 1'b1;
            repeat (2) @(negedge clock);
            check_cleared();
         end
      join
      #2 reset = 1'b0;
      wait_ticks(6);
      fork
         send(0, 9'h0C6, 1'b0, 2'b00, 1'b1);
         send(1, 9'h0C6, 1'b0, 2'b00, 1'b1);
         send(2, 9'h0C6, 1'b0, 2'b00, 1'b1);
      join

      guard = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) > 0 && guard < 3000) begin
         @(posedge clock);
         guard++;
      end
      for (int l = 0; l < 3; l++) chk("drain", l, 32'(q[l].size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
